// File: rtl/datapath_pipe.sv
// Two-stage pipelined CR16-class datapath: register array, operand forwarding,
// registered writeback and status flags, plus the combinational alu it drives.

module alu #(
  parameter int P_WIDTH = 16
) (
  input  logic [P_WIDTH-1:0] a_i,
  input  logic [P_WIDTH-1:0] b_i,
  input  logic [3:0]         opcode_i,
  output logic [P_WIDTH-1:0] result_o,
  output logic [4:0]         flags_o
);
  localparam int L_MSB  = P_WIDTH - 1;
  localparam int L_SH_W = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;

  logic [P_WIDTH:0]   sum_s;
  logic [P_WIDTH:0]   diff_s;
  logic [P_WIDTH-1:0] res_s;
  logic [L_SH_W-1:0]  sh_s;
  logic               c_s;
  logic               f_s;
  logic               l_s;

  // Flags are {N, Z, L(signed less), F(overflow), C(carry/borrow)}
  always_comb begin
    sum_s  = {1'b0, a_i} + {1'b0, b_i};
    diff_s = {1'b0, a_i} - {1'b0, b_i};
    sh_s   = b_i[L_SH_W-1:0];
    res_s  = '0;
    c_s    = 1'b0;
    f_s    = 1'b0;
    l_s    = 1'b0;
    case (opcode_i)
      4'd0: begin
        res_s = sum_s[P_WIDTH-1:0];
        c_s   = sum_s[P_WIDTH];
        f_s   = (a_i[L_MSB] == b_i[L_MSB]) && (sum_s[L_MSB] != a_i[L_MSB]);
      end
      4'd1, 4'd2: begin
        res_s = diff_s[P_WIDTH-1:0];
        c_s   = diff_s[P_WIDTH];
        f_s   = (a_i[L_MSB] != b_i[L_MSB]) && (diff_s[L_MSB] != a_i[L_MSB]);
        l_s   = diff_s[L_MSB] ^ f_s;
      end
      4'd3:    res_s = a_i & b_i;
      4'd4:    res_s = a_i | b_i;
      4'd5:    res_s = a_i ^ b_i;
      4'd6:    res_s = ~a_i;
      4'd7:    res_s = b_i;
      4'd8:    res_s = a_i << sh_s;
      4'd9:    res_s = a_i >> sh_s;
      4'd10:   res_s = $signed(a_i) >>> sh_s;
      default: res_s = '0;
    endcase
    result_o = res_s;
    flags_o  = {res_s[L_MSB], (res_s == '0), l_s, f_s, c_s};
  end
endmodule

module datapath_pipe #(
  parameter  int P_WIDTH    = 16,
  parameter  int P_NUM_REGS = 16,
  parameter  int P_FORWARD  = 1,
  parameter  int P_ZERO_REG = 0,
  localparam int L_SEL_W    = $clog2(P_NUM_REGS)
) (
  input  logic               I_CLK,
  input  logic               I_RESET,
  input  logic               I_ENABLE,
  input  logic               I_VALID,
  input  logic [L_SEL_W-1:0] I_REG_A_SELECT,
  input  logic [L_SEL_W-1:0] I_REG_B_SELECT,
  input  logic [P_WIDTH-1:0] I_IMMEDIATE,
  input  logic               I_IMMEDIATE_SELECT,
  input  logic [3:0]         I_OPCODE,
  input  logic [L_SEL_W-1:0] I_DEST_SELECT,
  input  logic               I_DEST_WRITE,
  input  logic               I_FLAGS_WRITE,
  input  logic [P_WIDTH-1:0] I_EXT_DATA,
  input  logic               I_EXT_SELECT,
  output logic [P_WIDTH-1:0] O_A,
  output logic [P_WIDTH-1:0] O_B,
  output logic               O_RESULT_VALID,
  output logic [P_WIDTH-1:0] O_RESULT,
  output logic [4:0]         O_STATUS_FLAGS
);
  localparam bit L_FWD  = (P_FORWARD != 0);
  localparam bit L_ZERO = (P_ZERO_REG != 0);

  logic [P_WIDTH-1:0] regs_q [P_NUM_REGS];

  logic               s1_valid_q;
  logic [P_WIDTH-1:0] s1_a_q;
  logic [P_WIDTH-1:0] s1_b_q;
  logic [3:0]         s1_op_q;
  logic [L_SEL_W-1:0] s1_dest_q;
  logic               s1_dw_q;
  logic               s1_fw_q;
  logic               s1_ext_sel_q;
  logic [P_WIDTH-1:0] s1_ext_q;

  logic               s2_valid_q;
  logic [P_WIDTH-1:0] s2_result_q;
  logic [L_SEL_W-1:0] s2_dest_q;
  logic               s2_dw_q;
  logic [4:0]         flags_q;

  logic [P_WIDTH-1:0] alu_res_s;
  logic [4:0]         alu_flags_s;
  logic [P_WIDTH-1:0] s2_result_d;
  logic [P_WIDTH-1:0] rd_a_s;
  logic [P_WIDTH-1:0] rd_b_s;
  logic [P_WIDTH-1:0] op_a_d;
  logic               s1_hit_a_s;
  logic               s1_hit_b_s;
  logic               s2_hit_a_s;
  logic               s2_hit_b_s;

  alu #(.P_WIDTH(P_WIDTH)) u_alu (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .opcode_i (s1_op_q),
    .result_o (alu_res_s),
    .flags_o  (alu_flags_s)
  );

  // Operand resolution: zero register, then younger S1, then S2, then the array
  always_comb begin
    s2_result_d = s1_ext_sel_q ? s1_ext_q : alu_res_s;
    s1_hit_a_s  = L_FWD && s1_valid_q && s1_dw_q && (s1_dest_q == I_REG_A_SELECT);
    s1_hit_b_s  = L_FWD && s1_valid_q && s1_dw_q && (s1_dest_q == I_REG_B_SELECT);
    s2_hit_a_s  = L_FWD && s2_valid_q && s2_dw_q && (s2_dest_q == I_REG_A_SELECT);
    s2_hit_b_s  = L_FWD && s2_valid_q && s2_dw_q && (s2_dest_q == I_REG_B_SELECT);
    if (L_ZERO && (I_REG_A_SELECT == '0)) begin
      rd_a_s = '0;
    end else if (s1_hit_a_s) begin
      rd_a_s = s2_result_d;
    end else if (s2_hit_a_s) begin
      rd_a_s = s2_result_q;
    end else begin
      rd_a_s = regs_q[I_REG_A_SELECT];
    end
    if (L_ZERO && (I_REG_B_SELECT == '0)) begin
      rd_b_s = '0;
    end else if (s1_hit_b_s) begin
      rd_b_s = s2_result_d;
    end else if (s2_hit_b_s) begin
      rd_b_s = s2_result_q;
    end else begin
      rd_b_s = regs_q[I_REG_B_SELECT];
    end
    op_a_d = I_IMMEDIATE_SELECT ? I_IMMEDIATE : rd_a_s;
  end

  // Pipeline stages, flag register and register array; everything freezes when disabled
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= 4'd0;
      s1_dest_q    <= '0;
      s1_dw_q      <= 1'b0;
      s1_fw_q      <= 1'b0;
      s1_ext_sel_q <= 1'b0;
      s1_ext_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_dest_q    <= '0;
      s2_dw_q      <= 1'b0;
      flags_q      <= 5'd0;
      for (int i = 0; i < P_NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (I_ENABLE) begin
      s1_valid_q   <= I_VALID;
      s1_a_q       <= op_a_d;
      s1_b_q       <= rd_b_s;
      s1_op_q      <= I_OPCODE;
      s1_dest_q    <= I_DEST_SELECT;
      s1_dw_q      <= I_DEST_WRITE;
      s1_fw_q      <= I_FLAGS_WRITE;
      s1_ext_sel_q <= I_EXT_SELECT;
      s1_ext_q     <= I_EXT_DATA;
      s2_valid_q   <= s1_valid_q;
      s2_dest_q    <= s1_dest_q;
      s2_dw_q      <= s1_dw_q;
      // O_RESULT keeps the last real result across bubbles
      if (s1_valid_q) begin
        s2_result_q <= s2_result_d;
      end
      if (s1_valid_q && s1_fw_q && !s1_ext_sel_q) begin
        flags_q <= alu_flags_s;
      end
      if (s2_valid_q && s2_dw_q && !(L_ZERO && (s2_dest_q == '0))) begin
        regs_q[s2_dest_q] <= s2_result_q;
      end
    end
  end

  assign O_A            = s1_a_q;
  assign O_B            = s1_b_q;
  assign O_RESULT_VALID = s2_valid_q;
  assign O_RESULT       = s2_result_q;
  assign O_STATUS_FLAGS = flags_q;
endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: a default 16-bit instance and a 32-bit,
// 32-register instance with the hardwired zero register.

module tb_datapath_pipe;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_CMP = 4'd2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en1, v1, imsel1, dw1, fw1, xsel1;
  logic [3:0]  asel1, bsel1, dest1, op1;
  logic [15:0] imm1, ext1, a1, b1, res1;
  logic        rv1;
  logic [4:0]  flags1;

  logic        en2, v2, imsel2, dw2, fw2, xsel2;
  logic [4:0]  asel2, bsel2, dest2;
  logic [3:0]  op2;
  logic [31:0] imm2, ext2, a2, b2, res2;
  logic        rv2;
  logic [4:0]  flags2;

  int n_cmp = 0;
  int n_err = 0;

  datapath_pipe dut1 (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en1), .I_VALID(v1),
    .I_REG_A_SELECT(asel1), .I_REG_B_SELECT(bsel1), .I_IMMEDIATE(imm1),
    .I_IMMEDIATE_SELECT(imsel1), .I_OPCODE(op1), .I_DEST_SELECT(dest1),
    .I_DEST_WRITE(dw1), .I_FLAGS_WRITE(fw1), .I_EXT_DATA(ext1),
    .I_EXT_SELECT(xsel1), .O_A(a1), .O_B(b1), .O_RESULT_VALID(rv1),
    .O_RESULT(res1), .O_STATUS_FLAGS(flags1)
  );

  datapath_pipe #(.P_WIDTH(32), .P_NUM_REGS(32), .P_FORWARD(1), .P_ZERO_REG(1)) dut2 (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en2), .I_VALID(v2),
    .I_REG_A_SELECT(asel2), .I_REG_B_SELECT(bsel2), .I_IMMEDIATE(imm2),
    .I_IMMEDIATE_SELECT(imsel2), .I_OPCODE(op2), .I_DEST_SELECT(dest2),
    .I_DEST_WRITE(dw2), .I_FLAGS_WRITE(fw2), .I_EXT_DATA(ext2),
    .I_EXT_SELECT(xsel2), .O_A(a2), .O_B(b2), .O_RESULT_VALID(rv2),
    .O_RESULT(res2), .O_STATUS_FLAGS(flags2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iss1(input logic [3:0] op, input logic [3:0] dest, input logic [3:0] asel,
                      input logic [3:0] bsel, input logic [15:0] imm, input logic immsel,
                      input logic dw, input logic fw);
    v1 = 1'b1; op1 = op; dest1 = dest; asel1 = asel; bsel1 = bsel; imm1 = imm;
    imsel1 = immsel; dw1 = dw; fw1 = fw; xsel1 = 1'b0; ext1 = 16'h0000;
  endtask

  task automatic bub1();
    v1 = 1'b0; dw1 = 1'b0; fw1 = 1'b0; xsel1 = 1'b0;
  endtask

  task automatic iss2(input logic [3:0] op, input logic [4:0] dest, input logic [4:0] asel,
                      input logic [4:0] bsel, input logic [31:0] imm, input logic immsel,
                      input logic dw);
    v2 = 1'b1; op2 = op; dest2 = dest; asel2 = asel; bsel2 = bsel; imm2 = imm;
    imsel2 = immsel; dw2 = dw;
  endtask

  task automatic bub2();
    v2 = 1'b0; dw2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en1 = 1'b1; op1 = OP_ADD; dest1 = 4'd0; asel1 = 4'd0; bsel1 = 4'd0;
    imm1 = 16'h0000; imsel1 = 1'b0; ext1 = 16'h0000; bub1();
    en2 = 1'b1; op2 = OP_ADD; dest2 = 5'd0; asel2 = 5'd0; bsel2 = 5'd0;
    imm2 = 32'h0; imsel2 = 1'b0; fw2 = 1'b0; xsel2 = 1'b0; ext2 = 32'h0; bub2();
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_valid", {31'd0, rv1}, 32'd0);
    check_eq("rst_result", {16'd0, res1}, 32'd0);
    check_eq("rst_flags", {27'd0, flags1}, 32'd0);
    check_eq("rst_a", {16'd0, a1}, 32'd0);
    check_eq("rst_valid2", {31'd0, rv2}, 32'd0);

    // r1 <- imm 5 + r0: two-edge latency, array read from T+3
    iss1(OP_ADD, 4'd1, 4'd0, 4'd0, 16'd5, 1'b1, 1'b1, 1'b0); tick();
    check_eq("imm_opa", {16'd0, a1}, 32'd5);
    check_eq("imm_not_yet", {31'd0, rv1}, 32'd0);
    bub1(); tick();
    check_eq("imm_valid", {31'd0, rv1}, 32'd1);
    check_eq("imm_result", {16'd0, res1}, 32'd5);
    bub1(); tick();
    iss1(OP_ADD, 4'd6, 4'd0, 4'd1, 16'd0, 1'b1, 1'b0, 1'b0); tick();
    check_eq("r1_array", {16'd0, b1}, 32'd5);

    // back-to-back dependent chain through S1 and S2 bypasses
    iss1(OP_ADD, 4'd1, 4'd0, 4'd0, 16'd7, 1'b1, 1'b1, 1'b0); tick();
    iss1(OP_ADD, 4'd2, 4'd1, 4'd1, 16'd0, 1'b0, 1'b1, 1'b0); tick();
    check_eq("fwd_s1_a", {16'd0, a1}, 32'd7);
    check_eq("fwd_s1_b", {16'd0, b1}, 32'd7);
    check_eq("chain_res7", {16'd0, res1}, 32'd7);
    iss1(OP_ADD, 4'd3, 4'd1, 4'd2, 16'd0, 1'b0, 1'b1, 1'b0); tick();
    check_eq("fwd_s2_a", {16'd0, a1}, 32'd7);
    check_eq("fwd_s1_b2", {16'd0, b1}, 32'd14);
    check_eq("chain_res14", {16'd0, res1}, 32'd14);
    iss1(OP_ADD, 4'd7, 4'd0, 4'd0, 16'd1, 1'b1, 1'b1, 1'b0); tick();
    check_eq("chain_res21", {16'd0, res1}, 32'd21);
    iss1(OP_ADD, 4'd7, 4'd0, 4'd0, 16'd2, 1'b1, 1'b1, 1'b0); tick();
    iss1(OP_ADD, 4'd8, 4'd0, 4'd7, 16'd0, 1'b1, 1'b1, 1'b0); tick();
    check_eq("younger_wins", {16'd0, b1}, 32'd2);

    // stall with r4 in S1 and r8 (result 2) in S2
    iss1(OP_ADD, 4'd4, 4'd0, 4'd0, 16'd9, 1'b1, 1'b1, 1'b0); tick();
    check_eq("pre_stall_res", {16'd0, res1}, 32'd2);
    en1 = 1'b0;
    iss1(OP_ADD, 4'd4, 4'd0, 4'd0, 16'd100, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_res", {16'd0, res1}, 32'd2);
      check_eq("stall_valid", {31'd0, rv1}, 32'd1);
      check_eq("stall_s1_a", {16'd0, a1}, 32'd9);
    end
    en1 = 1'b1; bub1(); tick();
    check_eq("post_stall_res", {16'd0, res1}, 32'd9);
    check_eq("post_stall_valid", {31'd0, rv1}, 32'd1);
    bub1(); tick();
    check_eq("post_stall_drain", {31'd0, rv1}, 32'd0);
    tick();

    // CMP 3 vs r4=9: N=1 Z=0 L=1 F=0 C=1; the ext load must not touch flags
    iss1(OP_CMP, 4'd0, 4'd0, 4'd4, 16'd3, 1'b1, 1'b0, 1'b1); tick();
    check_eq("flag_latency", {27'd0, flags1}, 32'd0);
    iss1(OP_ADD, 4'd5, 4'd0, 4'd0, 16'd0, 1'b1, 1'b1, 1'b1);
    xsel1 = 1'b1; ext1 = 16'hBEEF; tick();
    check_eq("cmp_flags", {27'd0, flags1}, 32'h15);
    bub1(); tick();
    check_eq("ext_result", {16'd0, res1}, 32'h0000BEEF);
    check_eq("ext_keeps_flags", {27'd0, flags1}, 32'h15);
    bub1(); tick();
    iss1(OP_ADD, 4'd6, 4'd0, 4'd5, 16'd0, 1'b1, 1'b0, 1'b0); tick();
    check_eq("r5_array", {16'd0, b1}, 32'h0000BEEF);
    bub1(); tick(); tick();

    // reset while a write to r3 sits in S2
    iss1(OP_ADD, 4'd3, 4'd0, 4'd0, 16'h0055, 1'b1, 1'b1, 1'b0); tick();
    bub1(); tick();
    check_eq("pre_rst_res", {16'd0, res1}, 32'h55);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check_eq("mid_rst_valid", {31'd0, rv1}, 32'd0);
    check_eq("mid_rst_flags", {27'd0, flags1}, 32'd0);
    check_eq("mid_rst_result", {16'd0, res1}, 32'd0);
    iss1(OP_ADD, 4'd6, 4'd0, 4'd3, 16'd0, 1'b1, 1'b0, 1'b0); tick();
    check_eq("r3_after_rst", {16'd0, b1}, 32'd0);
    bub1(); tick();

    // 32-bit instance: hardwired r0 and top index r31
    iss2(OP_ADD, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1); tick();
    iss2(OP_ADD, 5'd9, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0); tick();
    check_eq("r0_no_fwd_s1", b2, 32'd0);
    iss2(OP_ADD, 5'd31, 5'd0, 5'd0, 32'h1234_5678, 1'b1, 1'b1); tick();
    check_eq("r0_no_fwd_s2", b2, 32'd0);
    iss2(OP_ADD, 5'd1, 5'd0, 5'd31, 32'd1, 1'b1, 1'b0); tick();
    check_eq("r31_fwd", b2, 32'h1234_5678);
    bub2(); tick(); tick(); tick();
    iss2(OP_ADD, 5'd2, 5'd0, 5'd31, 32'd0, 1'b0, 1'b0); tick();
    check_eq("r0_array", a2, 32'd0);
    check_eq("r31_array", b2, 32'h1234_5678);
    iss2(OP_ADD, 5'd2, 5'd15, 5'd15, 32'd0, 1'b0, 1'b0); tick();
    check_eq("r15_untouched", b2, 32'd0);
    check_eq("r31_result", res2, 32'h1234_5678);
    bub2(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
